// File: rtl/pingpong_game_ctrl.sv
// Ping-pong game-rule engine: serve/rally/score state machine driving a
// one-hot ball LED strip and per-player scores for the score display.
module pingpong_game_ctrl #(
  parameter int unsigned LED_N     = 16,
  parameter int unsigned WIN_SCORE = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn_p1,
  input  logic             btn_p2,
  output logic [1:0]       game_state,
  output logic [3:0]       p1_score,
  output logic [3:0]       p2_score,
  output logic [LED_N-1:0] ball_led,
  output logic             point_p1,
  output logic             point_p2
);

  localparam int unsigned POS_W = (LED_N > 1) ? $clog2(LED_N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [POS_W-1:0] POS_FIRST = '0;
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(LED_N - 1);
  localparam logic [3:0]       WIN       = 4'(WIN_SCORE);

  // server/dir encoding: 0 = P1 side (left, pos 0), 1 = P2 side (right)
  logic [POS_W-1:0] pos, pos_n;
  logic             dir, dir_n;
  logic             server, server_n;
  logic [1:0]       state_n;
  logic [3:0]       p1_n, p2_n;
  logic             pt1_n, pt2_n;
  logic [LED_N-1:0] led_n;
  logic             award_p1, award_p2;
  logic             rcv_btn, at_end, srv_btn;

  always_comb begin
    rcv_btn = dir ? btn_p1 : btn_p2;
    at_end  = dir ? (pos == POS_FIRST) : (pos == POS_LAST);
    srv_btn = server ? btn_p2 : btn_p1;
  end

  // Next-state, score and ball-motion logic
  always_comb begin
    state_n  = game_state;
    p1_n     = p1_score;
    p2_n     = p2_score;
    pos_n    = pos;
    dir_n    = dir;
    server_n = server;
    pt1_n    = 1'b0;
    pt2_n    = 1'b0;
    award_p1 = 1'b0;
    award_p2 = 1'b0;

    case (game_state)
      S_IDLE: begin
        if (btn_p1 || btn_p2) begin
          state_n  = S_SERVE;
          server_n = 1'b0;
          pos_n    = POS_FIRST;
          dir_n    = 1'b0;
        end
      end
      S_SERVE: begin
        pos_n = server ? POS_LAST : POS_FIRST;
        if (srv_btn) begin
          state_n = S_PLAY;
          dir_n   = server;
        end
      end
      S_PLAY: begin
        if (rcv_btn) begin
          if (at_end) begin
            dir_n = ~dir;
            if (tick) begin
              pos_n = dir ? (pos + POS_W'(1)) : (pos - POS_W'(1));
            end
          end else begin
            award_p1 = ~dir;
            award_p2 = dir;
          end
        end else if (tick) begin
          if (!at_end) begin
            pos_n = dir ? (pos - POS_W'(1)) : (pos + POS_W'(1));
          end else begin
            award_p1 = ~dir;
            award_p2 = dir;
          end
        end
      end
      default: begin
        if (btn_p1 || btn_p2) begin
          state_n  = S_IDLE;
          p1_n     = 4'd0;
          p2_n     = 4'd0;
          pos_n    = POS_FIRST;
          dir_n    = 1'b0;
          server_n = 1'b0;
        end
      end
    endcase

    // The loser of a point serves next from their own end
    if (award_p1) begin
      p1_n  = p1_score + 4'd1;
      pt1_n = 1'b1;
      if (p1_n == WIN) begin
        state_n = S_DONE;
      end else begin
        state_n  = S_SERVE;
        server_n = 1'b1;
        pos_n    = POS_LAST;
      end
    end else if (award_p2) begin
      p2_n  = p2_score + 4'd1;
      pt2_n = 1'b1;
      if (p2_n == WIN) begin
        state_n = S_DONE;
      end else begin
        state_n  = S_SERVE;
        server_n = 1'b0;
        pos_n    = POS_FIRST;
      end
    end

    led_n = '0;
    if (state_n == S_SERVE || state_n == S_PLAY) begin
      led_n = LED_N'(1) << pos_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      game_state <= S_IDLE;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      pos        <= POS_FIRST;
      dir        <= 1'b0;
      server     <= 1'b0;
      ball_led   <= '0;
      point_p1   <= 1'b0;
      point_p2   <= 1'b0;
    end else begin
      game_state <= state_n;
      p1_score   <= p1_n;
      p2_score   <= p2_n;
      pos        <= pos_n;
      dir        <= dir_n;
      server     <= server_n;
      ball_led   <= led_n;
      point_p1   <= pt1_n;
      point_p2   <= pt2_n;
    end
  end

endmodule

// File: doc/pingpong_game_ctrl.md
# pingpong_game_ctrl

Game-rule engine for the FPGA ping-pong design. It turns debounced player button pulses and a game-speed tick into ball motion on a 16-LED strip, hit/miss decisions, and per-player scores. Its `game_state`, `p1_score` and `p2_score` outputs feed the dot-matrix score/winner display directly; `ball_led` drives the LED strip.

## Interface
- `LED_N`, 16: ball track length in LEDs (4..16).
- `WIN_SCORE`, 7: points needed to win (1..7; the display renders digits 0..7).

- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `tick`  in  1  one-cycle ball-step enable from the game-speed divider.
- `btn_p1`  in  1  one-cycle debounced press pulse, player 1 (left end, pos 0).
- `btn_p2`  in  1  one-cycle debounced press pulse, player 2 (right end, pos LED_N-1).
- `game_state`  out  2  0=IDLE, 1=SERVE, 2=PLAY, 3=DONE.
- `p1_score`  out  4  player 1 points, 0..WIN_SCORE.
- `p2_score`  out  4  player 2 points, 0..WIN_SCORE.
- `ball_led`  out  LED_N  one-hot ball position; all zero in IDLE and DONE.
- `point_p1`  out  1  one-cycle pulse when player 1 scores.
- `point_p2`  out  1  one-cycle pulse when player 2 scores.

## Operation
- Internal registers:
  - `pos`: ball index.
  - `dir`: 0 = moving right toward P2, 1 = moving left toward P1.
  - `server`: which player serves.
- Reset (`reset`=0 at a clock edge): state IDLE, both scores 0, `pos`=0, `dir`=0, `server`=P1, `ball_led`=0, point pulses 0.

IDLE
- Either button → SERVE with `server`=P1 and `pos`=0.

SERVE
- Ball parks at the server's end: `pos`=0 for P1, LED_N-1 for P2.
- A press by the server → PLAY, with `dir` set toward the opponent.
- A press by the non-server is ignored. `tick` is ignored.

PLAY
- The receiver is P2 when `dir`=0 and P1 when `dir`=1. The non-receiver's button is ignored.
- Receiver press with ball at the receiver's end → hit: `dir` is reversed.
- Receiver press with ball elsewhere → early swing: the non-receiver scores immediately.
- On `tick`:
  - Ball not at the receiver's end → `pos` steps one place in `dir`.
  - Ball at the receiver's end and no hit latched → miss: the non-receiver scores.
- Press and `tick` in the same cycle with the ball at the end → counts as a hit. `dir` reverses and `pos` steps one place away from the end in that same cycle.

Point scored
- The scorer's count increments and its `point_pX` pulses for one cycle.
- New score == WIN_SCORE → DONE.
- Otherwise → SERVE, with `server` = the player who lost the point and the ball parked at that player's end.

DONE
- Scores are frozen and `ball_led`=0.
- Either button → IDLE with both scores cleared in the same edge.

Widths and limits
- Scores are 4-bit and never exceed WIN_SCORE.
- `pos` never leaves 0..LED_N-1; there is no wrap-around.

## Timing
- All outputs are registered. An input sampled at edge N is reflected at edge N.
- Outputs are visible in the cycle after edge N.
- Button → state change: 1 cycle.
- `tick` → `ball_led` shift: 1 cycle.
- Miss/early swing → score increment, `point_pX` pulse and state change all occur on the same edge.
- `btn_p1` and `btn_p2` in the same cycle: each is evaluated per the rules above.
  - IDLE/DONE: treated as a single press.
  - SERVE: only the server's press acts.
  - PLAY: only the receiver's press acts.
- Reset asserted mid-rally overrides everything at that edge; no point is awarded.
- `tick` asserted every cycle is legal; the ball moves one LED per cycle.

## Test plan
- Reset, then `btn_p1`, then `btn_p1` → SERVE, then PLAY, with `ball_led`=16'h0001. After 15 ticks `ball_led`=16'h8000. A 16th tick with no `btn_p2` → `p1_score`=1, `point_p1` pulse, state SERVE, `server`=P2, `ball_led`=16'h8000.
- Ball at pos 15 moving right, `btn_p2` pulse, then tick → `dir`=1, `ball_led`=16'h4000, no score change.
- Ball at pos 15, `btn_p2` and `tick` in the same cycle → hit, next `ball_led`=16'h4000.
- Ball at pos 9 moving right, `btn_p2` → `p1_score`+1 immediately, state SERVE.
- In PLAY with P1 at 6 points, P1 wins a point → `p1_score`=7, `game_state`=3, `ball_led`=0. Then `btn_p2` → `game_state`=0 and both scores 0.
- Reset asserted with the ball at pos 7 and `p2_score`=3 → next cycle: IDLE, scores 0, `ball_led`=0, no point pulse.
